logic_axi4_stream_arbiter_mux: RTL and testbench
================================================

// Module: logic_axi4_stream_arbiter_mux
// PURPOSE
//  N:1 AXI4-Stream multiplexer with packet-locked arbitration and a registered output stage.
//  - Selectable arbitration: round-robin or fixed priority.
//  - Once a packet starts, the grant holds until its TLAST beat.
//  - Optionally tags each beat's TID with the source index.
//  - Sits in front of shared stream consumers (DMA, packet FIFOs); flat-port boundary.
// PARAMETERS
//  INPUTS        4  number of rx streams, >=1
//  TDATA_BYTES   4  tdata width in bytes
//  TDEST_WIDTH   1  tdest width
//  TUSER_WIDTH   1  tuser width
//  TID_WIDTH     1  tid width
//  USE_TLAST     1  0: every beat is treated as last (per-beat arbitration)
//  USE_TKEEP     1  0: tx_tkeep driven all-ones
//  USE_TSTRB     1  0: tx_tstrb driven all-ones
//  ARBITRATION   0  0 round-robin, 1 fixed priority (lowest index wins)
//  TID_FROM_SRC  0  1: tx_tid = granted index, zero-extended; requires TID_WIDTH>=$clog2(INPUTS)
// PORTS
//  aclk       in   1                      clock; all logic on rising edge
//  areset     in   1                      asynchronous, active-high reset
//  rx_tvalid  in   INPUTS                 per-input valid
//  rx_tlast   in   INPUTS                 per-input last
//  rx_tdata   in   INPUTS*TDATA_BYTES*8   packed [INPUTS][TDATA_BYTES][8]
//  rx_tstrb   in   INPUTS*TDATA_BYTES     byte strobes
//  rx_tkeep   in   INPUTS*TDATA_BYTES     byte keeps
//  rx_tdest   in   INPUTS*TDEST_WIDTH     routing
//  rx_tuser   in   INPUTS*TUSER_WIDTH     sideband
//  rx_tid     in   INPUTS*TID_WIDTH       stream id
//  rx_tready  out  INPUTS                 per-input ready; at most one bit high
//  tx_tvalid/tx_tlast/tx_tdata/tx_tstrb/tx_tkeep/tx_tdest/tx_tuser/tx_tid  out  single-stream widths
//  tx_tready  in   1                      downstream ready
// BEHAVIOUR
//  Reset: tx_tvalid=0; all tx payload registers=0; state=IDLE; rr_ptr=0. rx_tready=0 while areset=1.
//  Output stage: one register.
//   - stage_ready = !tx_tvalid || tx_tready (combinational; no ready register).
//   - Latency is 1 cycle from rx handshake to tx_tvalid. Full throughput: one beat per cycle sustained.
//  IDLE:
//   - Arbiter picks winner w among rx_tvalid; rx_tready[w]=stage_ready, all others 0.
//   - Handshake with tlast=0 -> LOCKED, grant=w.
//   - Handshake with tlast=1 -> stay IDLE; round-robin only: rr_ptr=(w+1)%INPUTS.
//  LOCKED:
//   - rx_tready[grant]=stage_ready, all others 0.
//   - tvalid gaps on the granted input keep the lock.
//   - Handshake with tlast=1 -> IDLE; round-robin only: rr_ptr=(grant+1)%INPUTS.
//  Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping at INPUTS. Fixed priority ignores rr_ptr.
//  USE_TLAST=0: tlast is internally forced to 1, so there is no LOCKED entry; tx_tlast=1 on every beat.
//  tx_tid:
//   - TID_FROM_SRC=1: tx_tid = source index.
//   - TID_FROM_SRC=0: tx_tid = rx_tid.
//  Payload is captured only on handshake. tx holds stable while tx_tvalid && !tx_tready.
//  No-valid cycle in IDLE: all rx_tready=0; the output drains normally.
//  Reset mid-packet: lock is dropped and the partial packet is truncated; no recovery beat is emitted.
//  INPUTS=1: arbiter degenerates to rx_tready[0]=stage_ready.
// STRUCTURE
//  Package logic_axi4_stream_arbiter_mux_pkg:
//   - arbitration_t enum {ROUND_ROBIN, PRIORITY}
//   - state_t enum {IDLE, LOCKED}
//  Sub-module logic_arbiter_round_robin:
//   - Inputs: request vector, pointer, priority-mode flag.
//   - Output: one-hot grant plus index.
//   - Purely combinational.
//  Top module holds the FSM, rr_ptr, grant register, payload mux and output register.
// TESTING
//  1 Reset: hold areset 3 cycles with all rx_tvalid=1 -> rx_tready=0, tx_tvalid=0, tx_tdata=0.
//  2 RR fairness: INPUTS=4, all valid, 1-beat packets, tx_tready=1 -> source order 0,1,2,3,0; one beat per cycle.
//  3 Lock: in0 sends 3-beat packet 0xA0..0xA2, in1 valid throughout -> tx shows A0,A1,A2 contiguous, then in1's beat; rx_tready[1]=0 for 3 cycles.
//  4 Backpressure: tx_tready=0 for 5 cycles mid-packet -> tx payload stable; no rx handshakes; no beat lost or duplicated.
//  5 Priority mode: ARBITRATION=1, in2 and in3 valid -> in2 served until idle; TID_FROM_SRC=1 gives tx_tid=2.
//  6 Reset while LOCKED after beat 1 of 4 -> state IDLE, tx_tvalid=0; next arbitration starts at in0.

Source files
------------

// File: rtl/logic_axi4_stream_arbiter_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_axi4_stream_arbiter_mux_pkg                                        |
// | Shared types and helpers for the N:1 AXI4-Stream arbiter mux.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package logic_axi4_stream_arbiter_mux_pkg;

  typedef enum logic {
    ROUND_ROBIN = 1'b0,
    PRIORITY    = 1'b1
  } arbitration_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width that stays legal for a single-input configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_arbiter_round_robin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_arbiter_round_robin                                                |
// | Combinational rotating / fixed-priority request arbiter.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module logic_arbiter_round_robin
  import logic_axi4_stream_arbiter_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_priority,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_index,
  output logic          o_valid
);

  logic [PW-1:0]  w_base;
  logic [2*N-1:0] w_rot;
  int             w_sum;

  // Rotate a doubled request vector so the search always starts at bit 0.
  always_comb begin
    w_base  = i_priority ? '0 : i_ptr;
    w_rot   = {i_req, i_req} >> w_base;
    w_sum   = 0;
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_valid && w_rot[j]) begin
        o_valid = 1'b1;
        w_sum   = int'(w_base) + j;
        if (w_sum >= N) begin
          w_sum = w_sum - N;
        end
        o_index = PW'(w_sum);
      end
    end
    if (o_valid) begin
      o_grant = N'(1) << o_index;
    end
  end

endmodule
`default_nettype wire

// File: rtl/logic_axi4_stream_arbiter_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_axi4_stream_arbiter_mux                                            |
// | N:1 AXI4-Stream mux, packet-locked arbitration, registered output stage. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module logic_axi4_stream_arbiter_mux
  import logic_axi4_stream_arbiter_mux_pkg::*;
#(
  parameter int INPUTS       = 4,
  parameter int TDATA_BYTES  = 4,
  parameter int TDEST_WIDTH  = 1,
  parameter int TUSER_WIDTH  = 1,
  parameter int TID_WIDTH    = 1,
  parameter int USE_TLAST    = 1,
  parameter int USE_TKEEP    = 1,
  parameter int USE_TSTRB    = 1,
  parameter int ARBITRATION  = 0,
  parameter int TID_FROM_SRC = 0
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [INPUTS-1:0]               rx_tvalid,
  input  logic [INPUTS-1:0]               rx_tlast,
  input  logic [INPUTS*TDATA_BYTES*8-1:0] rx_tdata,
  input  logic [INPUTS*TDATA_BYTES-1:0]   rx_tstrb,
  input  logic [INPUTS*TDATA_BYTES-1:0]   rx_tkeep,
  input  logic [INPUTS*TDEST_WIDTH-1:0]   rx_tdest,
  input  logic [INPUTS*TUSER_WIDTH-1:0]   rx_tuser,
  input  logic [INPUTS*TID_WIDTH-1:0]     rx_tid,
  output logic [INPUTS-1:0]               rx_tready,
  output logic                            tx_tvalid,
  output logic                            tx_tlast,
  output logic [TDATA_BYTES*8-1:0]        tx_tdata,
  output logic [TDATA_BYTES-1:0]          tx_tstrb,
  output logic [TDATA_BYTES-1:0]          tx_tkeep,
  output logic [TDEST_WIDTH-1:0]          tx_tdest,
  output logic [TUSER_WIDTH-1:0]          tx_tuser,
  output logic [TID_WIDTH-1:0]            tx_tid,
  input  logic                            tx_tready
);

  localparam int   DW     = TDATA_BYTES * 8;
  localparam int   KW     = TDATA_BYTES;
  localparam int   PW     = idx_width(INPUTS);
  localparam logic c_prio = (ARBITRATION == int'(PRIORITY));

  state_t              r_state;
  state_t              w_state_next;
  logic [PW-1:0]       r_grant;
  logic [PW-1:0]       w_grant_next;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       w_rr_ptr_next;

  logic [INPUTS-1:0]   w_arb_onehot;
  logic [PW-1:0]       w_arb_index;
  logic                w_arb_valid;
  logic [INPUTS-1:0]   w_tlast_in;
  logic [PW-1:0]       w_sel;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic                w_stage_ready;
  logic                w_hs;

  logic [DW-1:0]          w_tdata;
  logic [KW-1:0]          w_tstrb;
  logic [KW-1:0]          w_tkeep;
  logic [TDEST_WIDTH-1:0] w_tdest;
  logic [TUSER_WIDTH-1:0] w_tuser;
  logic [TID_WIDTH-1:0]   w_tid;

  logic                   r_tx_tvalid;
  logic                   r_tx_tlast;
  logic [DW-1:0]          r_tx_tdata;
  logic [KW-1:0]          r_tx_tstrb;
  logic [KW-1:0]          r_tx_tkeep;
  logic [TDEST_WIDTH-1:0] r_tx_tdest;
  logic [TUSER_WIDTH-1:0] r_tx_tuser;
  logic [TID_WIDTH-1:0]   r_tx_tid;

  logic_arbiter_round_robin #(
    .N  (INPUTS),
    .PW (PW)
  ) u_arbiter (
    .i_req      (rx_tvalid),
    .i_ptr      (r_rr_ptr),
    .i_priority (c_prio),
    .o_grant    (w_arb_onehot),
    .o_index    (w_arb_index),
    .o_valid    (w_arb_valid)
  );

  assign w_tlast_in    = (USE_TLAST != 0) ? rx_tlast : '1;
  assign w_stage_ready = !r_tx_tvalid || tx_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // A held lock keeps ready on the granted input even through tvalid gaps.
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_rr_ptr_next = r_rr_ptr;
    w_sel         = w_arb_index;
    w_sel_valid   = w_arb_valid;
    rx_tready     = '0;
    if (r_state == LOCKED) begin
      w_sel       = r_grant;
      w_sel_valid = 1'b1;
    end
    if (w_sel_valid && !areset) begin
      rx_tready[w_sel] = w_stage_ready;
    end
    w_hs       = w_sel_valid && w_stage_ready && rx_tvalid[w_sel] && !areset;
    w_sel_last = w_tlast_in[w_sel];
    if (w_hs) begin
      if (w_sel_last) begin
        w_state_next = IDLE;
        if (!c_prio) begin
          w_rr_ptr_next = (w_sel == PW'(INPUTS - 1)) ? '0 : w_sel + PW'(1);
        end
      end else if (r_state == IDLE) begin
        w_state_next = LOCKED;
        w_grant_next = w_sel;
      end
    end
  end

  always_comb begin
    w_tdata = rx_tdata[w_sel*DW +: DW];
    w_tstrb = (USE_TSTRB != 0) ? rx_tstrb[w_sel*KW +: KW] : '1;
    w_tkeep = (USE_TKEEP != 0) ? rx_tkeep[w_sel*KW +: KW] : '1;
    w_tdest = rx_tdest[w_sel*TDEST_WIDTH +: TDEST_WIDTH];
    w_tuser = rx_tuser[w_sel*TUSER_WIDTH +: TUSER_WIDTH];
    w_tid   = (TID_FROM_SRC != 0) ? TID_WIDTH'(w_sel)
                                  : rx_tid[w_sel*TID_WIDTH +: TID_WIDTH];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tx_tvalid <= 1'b0;
      r_tx_tlast  <= 1'b0;
      r_tx_tdata  <= '0;
      r_tx_tstrb  <= '0;
      r_tx_tkeep  <= '0;
      r_tx_tdest  <= '0;
      r_tx_tuser  <= '0;
      r_tx_tid    <= '0;
    end else if (w_hs) begin
      r_tx_tvalid <= 1'b1;
      r_tx_tlast  <= w_sel_last;
      r_tx_tdata  <= w_tdata;
      r_tx_tstrb  <= w_tstrb;
      r_tx_tkeep  <= w_tkeep;
      r_tx_tdest  <= w_tdest;
      r_tx_tuser  <= w_tuser;
      r_tx_tid    <= w_tid;
    end else if (tx_tready) begin
      r_tx_tvalid <= 1'b0;
    end
  end

  assign tx_tvalid = r_tx_tvalid;
  assign tx_tlast  = r_tx_tlast;
  assign tx_tdata  = r_tx_tdata;
  assign tx_tstrb  = r_tx_tstrb;
  assign tx_tkeep  = r_tx_tkeep;
  assign tx_tdest  = r_tx_tdest;
  assign tx_tuser  = r_tx_tuser;
  assign tx_tid    = r_tx_tid;

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_stream_arbiter_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_axi4_stream_arbiter_mux                                         |
// | Directed bench: round-robin DUT plus a fixed-priority / source-TID DUT.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_logic_axi4_stream_arbiter_mux;

  logic         clk = 1'b0;
  logic         areset;
  logic [3:0]   rx_tvalid, rx_tlast;
  logic [127:0] rx_tdata;
  logic [15:0]  rx_tstrb, rx_tkeep;
  logic [3:0]   rx_tdest, rx_tuser, rx_tid;
  logic [7:0]   rx_tid_pr;
  logic         tx_tready;

  logic [3:0]  rr_rx_tready, pr_rx_tready;
  logic        rr_tx_tvalid, rr_tx_tlast, pr_tx_tvalid, pr_tx_tlast;
  logic [31:0] rr_tx_tdata, pr_tx_tdata;
  logic [3:0]  rr_tx_tstrb, rr_tx_tkeep, pr_tx_tstrb, pr_tx_tkeep;
  logic        rr_tx_tdest, rr_tx_tuser, pr_tx_tdest, pr_tx_tuser;
  logic        rr_tx_tid;
  logic [1:0]  pr_tx_tid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_axi4_stream_arbiter_mux u_rr (
    .aclk(clk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
    .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest),
    .rx_tuser(rx_tuser), .rx_tid(rx_tid), .rx_tready(rr_rx_tready),
    .tx_tvalid(rr_tx_tvalid), .tx_tlast(rr_tx_tlast), .tx_tdata(rr_tx_tdata),
    .tx_tstrb(rr_tx_tstrb), .tx_tkeep(rr_tx_tkeep), .tx_tdest(rr_tx_tdest),
    .tx_tuser(rr_tx_tuser), .tx_tid(rr_tx_tid), .tx_tready(tx_tready)
  );

  logic_axi4_stream_arbiter_mux #(
    .TID_WIDTH(2), .ARBITRATION(1), .TID_FROM_SRC(1)
  ) u_pr (
    .aclk(clk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
    .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest),
    .rx_tuser(rx_tuser), .rx_tid(rx_tid_pr), .rx_tready(pr_rx_tready),
    .tx_tvalid(pr_tx_tvalid), .tx_tlast(pr_tx_tlast), .tx_tdata(pr_tx_tdata),
    .tx_tstrb(pr_tx_tstrb), .tx_tkeep(pr_tx_tkeep), .tx_tdest(pr_tx_tdest),
    .tx_tuser(pr_tx_tuser), .tx_tid(pr_tx_tid), .tx_tready(tx_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [31:0] d);
    rx_tvalid[i]          = v;
    rx_tlast[i]           = l;
    rx_tdata[i*32 +: 32]  = d;
  endtask

  logic [3:0]  exp_rdy [1:5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [31:0] exp_dat [1:5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};
  logic        exp_tid [1:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0]  exp_kp  [1:5] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h1};

  initial begin
    areset    = 1'b1;
    tx_tready = 1'b1;
    rx_tvalid = 4'hF;
    rx_tlast  = 4'hF;
    rx_tdata  = '0;
    rx_tstrb  = 16'hF731;
    rx_tkeep  = 16'hF731;
    rx_tdest  = 4'b0101;
    rx_tuser  = 4'b0101;
    rx_tid    = 4'b1010;
    rx_tid_pr = '0;

    // Reset held with every input valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_rr_ready", 32'(rr_rx_tready), 32'h0);
      chk("rst_pr_ready", 32'(pr_rx_tready), 32'h0);
      chk("rst_tvalid",   32'(rr_tx_tvalid), 32'h0);
      chk("rst_tdata",    rr_tx_tdata,       32'h0);
    end

    // Round-robin fairness, single-beat packets
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 32'h10 + i);
    #1;
    chk("rr_ready0", 32'(rr_rx_tready), 32'b0001);
    chk("rr_tvalid0", 32'(rr_tx_tvalid), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk("rr_ready", 32'(rr_rx_tready), 32'(exp_rdy[k]));
      chk("rr_data",  rr_tx_tdata,       exp_dat[k]);
      chk("rr_valid", 32'(rr_tx_tvalid), 32'h1);
      chk("rr_tid",   32'(rr_tx_tid),    32'(exp_tid[k]));
      chk("rr_keep",  32'(rr_tx_tkeep),  32'(exp_kp[k]));
    end
    rx_tvalid = 4'h0;

    // Packet lock: in0 three beats while in1 waits
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'hA0);
    #1;
    chk("lk_idle_valid", 32'(rr_tx_tvalid), 32'h0);
    chk("lk_ready_a0",   32'(rr_rx_tready), 32'b0001);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'hA1);
    drive(1, 1'b1, 1'b1, 32'hB0);
    #1;
    chk("lk_ready_a1", 32'(rr_rx_tready), 32'b0001);
    chk("lk_data_a0",  rr_tx_tdata,       32'hA0);
    chk("lk_last_a0",  32'(rr_tx_tlast),  32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hA2);
    #1;
    chk("lk_ready_a2", 32'(rr_rx_tready), 32'b0001);
    chk("lk_data_a1",  rr_tx_tdata,       32'hA1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("lk_ready_b0", 32'(rr_rx_tready), 32'b0010);
    chk("lk_data_a2",  rr_tx_tdata,       32'hA2);
    chk("lk_last_a2",  32'(rr_tx_tlast),  32'h1);

    // Backpressure in the middle of a four-beat packet from in2
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0);
    drive(2, 1'b1, 1'b0, 32'hC0);
    #1;
    chk("bp_data_b0",  rr_tx_tdata,       32'hB0);
    chk("bp_ready_c0", 32'(rr_rx_tready), 32'b0100);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'hC1);
    tx_tready = 1'b0;
    #1;
    chk("bp_hold_data",  rr_tx_tdata,       32'hC0);
    chk("bp_hold_ready", 32'(rr_rx_tready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("bp_hold_data",  rr_tx_tdata,       32'hC0);
      chk("bp_hold_valid", 32'(rr_tx_tvalid), 32'h1);
      chk("bp_hold_ready", 32'(rr_rx_tready), 32'h0);
    end
    @(negedge clk);
    tx_tready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(rr_rx_tready), 32'b0100);
    chk("bp_rel_data",  rr_tx_tdata,       32'hC0);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'hC2);
    #1;
    chk("bp_data_c1", rr_tx_tdata, 32'hC1);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'hC3);
    #1;
    chk("bp_data_c2", rr_tx_tdata, 32'hC2);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0);
    #1;
    chk("bp_data_c3",  rr_tx_tdata,       32'hC3);
    chk("bp_last_c3",  32'(rr_tx_tlast),  32'h1);
    chk("bp_idle_rdy", 32'(rr_rx_tready), 32'h0);

    // Reset while locked after the first of four beats
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hD0);
    #1;
    chk("mr_drained",  32'(rr_tx_tvalid), 32'h0);
    chk("mr_ready_d0", 32'(rr_rx_tready), 32'b0010);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hD1);
    drive(0, 1'b1, 1'b1, 32'h5A);
    #1;
    chk("mr_data_d0",   rr_tx_tdata,       32'hD0);
    chk("mr_lock_ready", 32'(rr_rx_tready), 32'b0010);
    areset = 1'b1;
    #1;
    chk("mr_rst_valid", 32'(rr_tx_tvalid), 32'h0);
    chk("mr_rst_ready", 32'(rr_rx_tready), 32'h0);
    chk("mr_rst_data",  rr_tx_tdata,       32'h0);
    @(negedge clk);
    areset = 1'b0;
    drive(3, 1'b1, 1'b1, 32'h77);
    #1;
    chk("mr_restart_rr", 32'(rr_rx_tready), 32'b0001);
    chk("mr_restart_pr", 32'(pr_rx_tready), 32'b0001);

    // Fixed priority with source-index TID
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    drive(2, 1'b1, 1'b1, 32'hE0);
    drive(3, 1'b1, 1'b1, 32'hF0);
    #1;
    chk("pr_data_g0",  pr_tx_tdata,       32'h5A);
    chk("pr_tid_g0",   32'(pr_tx_tid),    32'h0);
    chk("pr_ready_e0", 32'(pr_rx_tready), 32'b0100);
    chk("rr_data_g0",  rr_tx_tdata,       32'h5A);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'hE1);
    #1;
    chk("pr_data_e0",  pr_tx_tdata,       32'hE0);
    chk("pr_tid_e0",   32'(pr_tx_tid),    32'h2);
    chk("pr_ready_e1", 32'(pr_rx_tready), 32'b0100);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'hE2);
    #1;
    chk("pr_data_e1",  pr_tx_tdata,       32'hE1);
    chk("pr_tid_e1",   32'(pr_tx_tid),    32'h2);
    chk("pr_ready_e2", 32'(pr_rx_tready), 32'b0100);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pr_data_e2",  pr_tx_tdata,       32'hE2);
    chk("pr_tid_e2",   32'(pr_tx_tid),    32'h2);
    chk("pr_ready_f0", 32'(pr_rx_tready), 32'b1000);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pr_data_f0", pr_tx_tdata,    32'hF0);
    chk("pr_tid_f0",  32'(pr_tx_tid), 32'h3);
    @(negedge clk); #1;
    chk("pr_drained", 32'(pr_tx_tvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
